// File: rtl/gate_multi_multi_lamp_if.sv
// gate_multi_multi_lamp_if: lamp strobes, mode select and pulse outputs; GATE_PULSE_COUNT_EN adds pulse_count
interface gate_multi_multi_lamp_if #(
    parameter int INPUT_COUNT  = 2,
    parameter int OUTPUT_COUNT = 2
);
    logic [INPUT_COUNT-1:0]  in;
    logic [2:0]              mode;
    logic [OUTPUT_COUNT-1:0] out;
    logic [INPUT_COUNT-1:0]  lamps;
    logic                    result;
`ifdef GATE_PULSE_COUNT_EN
    logic [15:0]             pulse_count;
    modport master (output in, mode, input out, lamps, result, pulse_count);
    modport slave  (input in, mode, output out, lamps, result, pulse_count);
`else
    modport master (output in, mode, input out, lamps, result);
    modport slave  (input in, mode, output out, lamps, result);
`endif
endinterface

// File: rtl/gate_multi_multi_lamp.sv
// gate_multi_multi_lamp: toggle lamps feeding a selectable gate function, pulsing all outputs when the result changes; GATE_PULSE_COUNT_EN adds a 16-bit pulse counter
module gate_multi_multi_lamp #(
    parameter int INPUT_COUNT  = 2,
    parameter int OUTPUT_COUNT = 2
) (
    input logic clk,
    input logic logic_reset,
    gate_multi_multi_lamp_if.slave bus
);
    localparam logic [0:0] PRIME = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;
    logic [0:0]             state;
    logic [INPUT_COUNT-1:0] lamps_next;
    logic                   all_on, any_on, one_on, eval;
    // gate function over the current lamps; reserved modes hold the last result
    always_comb begin
        lamps_next = bus.lamps ^ bus.in;
        all_on = &bus.lamps;
        any_on = |bus.lamps;
        one_on = $countones(bus.lamps) == 1;
        eval = bus.mode == 3'd0 ? all_on :
               bus.mode == 3'd1 ? any_on :
               bus.mode == 3'd2 ? one_on :
               bus.mode == 3'd3 ? !all_on :
               bus.mode == 3'd4 ? !any_on :
               bus.mode == 3'd5 ? !one_on : bus.result;
    end
    // lamp toggling, result tracking and change pulse; PRIME loads result silently
    always_ff @(posedge clk) begin
        if (logic_reset) begin
            bus.lamps  <= '0;
            bus.result <= 1'b0;
            bus.out    <= '0;
            state      <= PRIME;
        end else begin
            bus.lamps  <= lamps_next;
            bus.result <= eval;
            bus.out    <= {OUTPUT_COUNT{state == RUN && eval != bus.result}};
            state      <= RUN;
        end
    end
`ifdef GATE_PULSE_COUNT_EN
    // counts cycles with the pulse asserted, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (logic_reset) bus.pulse_count <= '0;
        else if (|bus.out) bus.pulse_count <= bus.pulse_count + 16'd1;
    end
`else
`endif
endmodule

// File: tb/tb_gate_multi_multi_lamp.sv
// tb_gate_multi_multi_lamp: table-driven scoreboard bench for gate_multi_multi_lamp (3 lamps, 4 outputs)
module tb_gate_multi_multi_lamp;
    localparam int NI = 3;
    localparam int NO = 4;
    typedef struct {
        logic          rst;
        logic [NI-1:0] in;
        logic [2:0]    mode;
        logic [NI-1:0] lamps;
        logic          res;
        logic          pulse;
    } vec_t;
    logic clk = 1'b0;
    logic logic_reset = 1'b1;
    int tests = 0;
    int failed = 0;
    vec_t tv[43];
    vec_t sb[$];
    gate_multi_multi_lamp_if #(.INPUT_COUNT(NI), .OUTPUT_COUNT(NO)) bus ();
    gate_multi_multi_lamp #(.INPUT_COUNT(NI), .OUTPUT_COUNT(NO)) dut (
        .clk(clk),
        .logic_reset(logic_reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        vec_t e;
`ifdef GATE_PULSE_COUNT_EN
        logic [15:0] exp_pc = 16'd0;
        logic prev_p = 1'b0;
`endif
        tv = '{
            '{1'b1, 3'b111, 3'd3, 3'b000, 1'b0, 1'b0},
            '{1'b0, 3'b000, 3'd3, 3'b000, 1'b1, 1'b0},
            '{1'b0, 3'b000, 3'd3, 3'b000, 1'b1, 1'b0},
            '{1'b0, 3'b001, 3'd0, 3'b001, 1'b0, 1'b1},
            '{1'b0, 3'b010, 3'd0, 3'b011, 1'b0, 1'b0},
            '{1'b0, 3'b100, 3'd0, 3'b111, 1'b0, 1'b0},
            '{1'b0, 3'b000, 3'd0, 3'b111, 1'b1, 1'b1},
            '{1'b0, 3'b000, 3'd0, 3'b111, 1'b1, 1'b0},
            '{1'b0, 3'b001, 3'd0, 3'b110, 1'b1, 1'b0},
            '{1'b0, 3'b000, 3'd0, 3'b110, 1'b0, 1'b1},
            '{1'b0, 3'b000, 3'd0, 3'b110, 1'b0, 1'b0},
            '{1'b0, 3'b110, 3'd2, 3'b000, 1'b0, 1'b0},
            '{1'b0, 3'b111, 3'd2, 3'b111, 1'b0, 1'b0},
            '{1'b0, 3'b000, 3'd2, 3'b111, 1'b0, 1'b0},
            '{1'b0, 3'b011, 3'd2, 3'b100, 1'b0, 1'b0},
            '{1'b0, 3'b000, 3'd2, 3'b100, 1'b1, 1'b1},
            '{1'b0, 3'b000, 3'd2, 3'b100, 1'b1, 1'b0},
            '{1'b0, 3'b001, 3'd2, 3'b101, 1'b1, 1'b0},
            '{1'b0, 3'b001, 3'd2, 3'b100, 1'b0, 1'b1},
            '{1'b0, 3'b000, 3'd2, 3'b100, 1'b1, 1'b1},
            '{1'b0, 3'b000, 3'd2, 3'b100, 1'b1, 1'b0},
            '{1'b0, 3'b110, 3'd1, 3'b010, 1'b1, 1'b0},
            '{1'b0, 3'b000, 3'd1, 3'b010, 1'b1, 1'b0},
            '{1'b0, 3'b010, 3'd1, 3'b000, 1'b1, 1'b0},
            '{1'b0, 3'b000, 3'd1, 3'b000, 1'b0, 1'b1},
            '{1'b0, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0},
            '{1'b0, 3'b000, 3'd4, 3'b000, 1'b1, 1'b1},
            '{1'b0, 3'b001, 3'd6, 3'b001, 1'b1, 1'b0},
            '{1'b0, 3'b011, 3'd6, 3'b010, 1'b1, 1'b0},
            '{1'b0, 3'b111, 3'd7, 3'b101, 1'b1, 1'b0},
            '{1'b0, 3'b000, 3'd5, 3'b101, 1'b1, 1'b0},
            '{1'b0, 3'b001, 3'd5, 3'b100, 1'b1, 1'b0},
            '{1'b0, 3'b000, 3'd5, 3'b100, 1'b0, 1'b1},
            '{1'b0, 3'b000, 3'd3, 3'b100, 1'b1, 1'b1},
            '{1'b1, 3'b111, 3'd3, 3'b000, 1'b0, 1'b0},
            '{1'b1, 3'b111, 3'd3, 3'b000, 1'b0, 1'b0},
            '{1'b0, 3'b101, 3'd0, 3'b101, 1'b0, 1'b0},
            '{1'b0, 3'b000, 3'd0, 3'b101, 1'b0, 1'b0},
            '{1'b0, 3'b010, 3'd0, 3'b111, 1'b0, 1'b0},
            '{1'b0, 3'b000, 3'd0, 3'b111, 1'b1, 1'b1},
            '{1'b1, 3'b000, 3'd3, 3'b000, 1'b0, 1'b0},
            '{1'b0, 3'b000, 3'd3, 3'b000, 1'b1, 1'b0},
            '{1'b0, 3'b000, 3'd3, 3'b000, 1'b1, 1'b0}
        };
        bus.in = '0;
        bus.mode = 3'd0;
        step();
        for (int i = 0; i < 43; i++) begin
            logic_reset = tv[i].rst;
            bus.in = tv[i].in;
            bus.mode = tv[i].mode;
            sb.push_back(tv[i]);
            step();
            if (sb.size() == 0) begin
                check($sformatf("v%0d scoreboard", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d lamps", i), 32'(bus.lamps), 32'(e.lamps));
                check($sformatf("v%0d result", i), 32'(bus.result), 32'(e.res));
                check($sformatf("v%0d out", i), 32'(bus.out), 32'({NO{e.pulse}}));
`ifdef GATE_PULSE_COUNT_EN
                exp_pc = e.rst ? 16'd0 : exp_pc + 16'(prev_p);
                prev_p = e.rst ? 1'b0 : e.pulse;
                check($sformatf("v%0d pulse_count", i), 32'(bus.pulse_count), 32'(exp_pc));
`endif
            end
        end
`ifdef GATE_PULSE_COUNT_EN
        logic_reset = 1'b1;
        bus.in = '0;
        bus.mode = 3'd3;
        step();
        check("wrap reset pulse_count", 32'(bus.pulse_count), 32'd0);
        logic_reset = 1'b0;
        step();
        for (int k = 0; k < 65536; k++) begin
            bus.mode = k[0] ? 3'd3 : 3'd0;
            step();
        end
        check("wrap pre pulse_count", 32'(bus.pulse_count), 32'hFFFF);
        check("wrap pre out", 32'(bus.out), 32'hF);
        step();
        check("wrap pulse_count", 32'(bus.pulse_count), 32'd0);
        check("wrap out", 32'(bus.out), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
